// File: rtl/dvp_cam_emu.sv
// dvp_cam_emu: DVP (OV2640-style) camera-sensor emulator.
// Drives VSYNC / HREF / 10-bit pixel data with frame and line timing and
// deterministic test patterns. PIXCLK is I_clk.
// Optional frame CRC-16-CCITT over O_pixdata[9:2] is built when
// DVP_EMU_CRC_EN is defined; otherwise O_crc/O_crc_valid are tied to 0.
module dvp_cam_emu #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BPORCH = 17,
  parameter int V_FPORCH = 10,
  parameter int BPP      = 1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_en,
  input  logic [1:0]  I_mode,
  output logic        O_vsync,
  output logic        O_href,
  output logic [9:0]  O_pixdata,
  output logic [15:0] O_frame_cnt,
  output logic        O_busy,
  output logic [15:0] O_crc,
  output logic        O_crc_valid
);

  localparam int          LINE_LEN = H_ACTIVE * BPP + H_BLANK;
  localparam int unsigned HREF_LEN = H_ACTIVE * BPP;
  localparam int          V_MAX_A  = (VS_LINES > V_BPORCH) ? VS_LINES : V_BPORCH;
  localparam int          V_MAX_B  = (V_ACTIVE > V_FPORCH) ? V_ACTIVE : V_FPORCH;
  localparam int          V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int          HW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int          VW       = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  state_t        state, state_nx;
  logic [HW-1:0] h_cnt, h_nx;
  logic [VW-1:0] v_cnt, v_nx, v_last;
  logic [1:0]    mode, mode_nx;
  logic          frame_done;
  logic [31:0]   h_wide;
  logic [9:0]    x, y, pat;
  logic          second_byte;
  logic          vsync_nx, href_nx;
  logic [9:0]    pix_nx;

  // Number of lines (minus one) spent in the current state.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    v_last = '0;
    case (state)
      S_VSYNC:  v_last = VW'(VS_LINES - 1);
      S_VBP:    v_last = VW'(V_BPORCH - 1);
      S_ACTIVE: v_last = VW'(V_ACTIVE - 1);
      S_VFP:    v_last = VW'(V_FPORCH - 1);
      default:  v_last = '0;
    endcase
  end

  // Next-state, line/pixel counters and pattern-mode latch.
  always_comb begin
    state_nx   = state;
    h_nx       = h_cnt;
    v_nx       = v_cnt;
    mode_nx    = mode;
    frame_done = 1'b0;
    if (state == S_IDLE) begin
      if (I_en) begin
        state_nx = S_VSYNC;
        h_nx     = '0;
        v_nx     = '0;
        mode_nx  = I_mode;
      end
    end else if (h_cnt != HW'(LINE_LEN - 1)) begin
      h_nx = h_cnt + HW'(1);
    end else begin
      h_nx = '0;
      if (v_cnt != v_last) begin
        v_nx = v_cnt + VW'(1);
      end else begin
        v_nx = '0;
        case (state)
          S_VSYNC:  state_nx = S_VBP;
          S_VBP:    state_nx = S_ACTIVE;
          S_ACTIVE: state_nx = S_VFP;
          default: begin
            // End of front porch: frame complete, restart only if still enabled.
            frame_done = 1'b1;
            if (I_en) begin
              state_nx = S_VSYNC;
              mode_nx  = I_mode;
            end else begin
              state_nx = S_IDLE;
            end
          end
        endcase
      end
    end
  end

  // Output values for the coming clock, decoded from the next counter state
  // so that the registered pins line up with the FSM.
  always_comb begin
    h_wide      = 32'(h_nx);
    x           = 10'(h_wide >> (BPP - 1));
    y           = 10'(v_nx);
    second_byte = (BPP == 2) && h_nx[0];
    case (mode)
      2'd0:    pat = x;
      2'd1:    pat = y;
      2'd2:    pat = (x[3] ^ y[3]) ? 10'h3FF : 10'h000;
      default: pat = {O_frame_cnt[7:0], 2'b00};
    endcase
    vsync_nx = (state_nx == S_VSYNC) ? VS_POL : ~VS_POL;
    href_nx  = (state_nx == S_ACTIVE) && (h_wide < HREF_LEN);
    pix_nx   = href_nx ? (second_byte ? ~pat : pat) : 10'h000;
  end

  // FSM, counters and registered sensor pins.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= S_IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode        <= '0;
      O_vsync     <= ~VS_POL;
      O_href      <= 1'b0;
      O_pixdata   <= '0;
      O_frame_cnt <= '0;
      O_busy      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state     <= state_nx;
      h_cnt     <= h_nx;
      v_cnt     <= v_nx;
      mode      <= mode_nx;
      O_vsync   <= vsync_nx;
      O_href    <= href_nx;
      O_pixdata <= pix_nx;
      O_busy    <= (state_nx != S_IDLE);
      if (frame_done) O_frame_cnt <= O_frame_cnt + 16'd1;
    end
  end

`ifdef DVP_EMU_CRC_EN
  logic [15:0] crc_acc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // Frame CRC: seeded on VSYNC entry, fed by each HREF byte, published on VFP entry.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      crc_acc     <= 16'hFFFF;
      O_crc       <= '0;
      O_crc_valid <= 1'b0;
    end else begin
      O_crc_valid <= 1'b0;
      if (state_nx == S_VSYNC && state != S_VSYNC) begin
        crc_acc <= 16'hFFFF;
      end else if (O_href) begin
        crc_acc <= crc_step(crc_acc, O_pixdata[9:2]);
      end
      // H_BLANK >= 1 guarantees the last active byte is already folded in here.
      if (state == S_ACTIVE && state_nx == S_VFP) begin
        O_crc       <= crc_acc;
        O_crc_valid <= 1'b1;
      end
    end
  end
`else
  assign O_crc       = '0;
  assign O_crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dvp_cam_emu.sv
// tb_dvp_cam_emu: self-checking bench for dvp_cam_emu.
// Two instances: A (4x3, BPP=1, VSYNC active high) and B (16x3, BPP=2,
// VSYNC active low). Expected streams come from a frame-geometry model that
// maps a cycle index within the frame to (vsync, href, pixel).
module tb_dvp_cam_emu;

  localparam int HA_A = 4,  VA_A = 3, HB_A = 2, VS_A = 1, VBP_A = 1, VFP_A = 1, BPP_A = 1;
  localparam bit POL_A = 1'b1;
  localparam int HA_B = 16, VA_B = 3, HB_B = 2, VS_B = 1, VBP_B = 1, VFP_B = 1, BPP_B = 2;
  localparam bit POL_B = 1'b0;

  typedef struct {
    int ha, va, hb, vs, vbp, vfp, bpp;
    bit pol;
  } cfg_t;

  typedef struct packed {
    logic       vsync;
    logic       href;
    logic [9:0] pix;
    logic       strobe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd0;

  logic vs_a, href_a, busy_a, crcv_a, vs_b, href_b, busy_b, crcv_b;
  logic [9:0] pix_a, pix_b;
  logic [15:0] fc_a, fc_b, crc_a, crc_b;

  bit sel = 1'b0;  // 0 selects instance A, 1 selects instance B
  logic obs_vsync, obs_href, obs_busy, obs_crc_valid;
  logic [9:0] obs_pix;
  logic [15:0] obs_fc, obs_crc;

  int vectors = 0;
  int miscompares = 0;
  int exp_fc[2] = '{0, 0};

  dvp_cam_emu #(
    .H_ACTIVE(HA_A), .V_ACTIVE(VA_A), .H_BLANK(HB_A), .VS_LINES(VS_A),
    .V_BPORCH(VBP_A), .V_FPORCH(VFP_A), .BPP(BPP_A), .VS_POL(POL_A)
  ) dut_a (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en_a), .I_mode(mode_a),
    .O_vsync(vs_a), .O_href(href_a), .O_pixdata(pix_a), .O_frame_cnt(fc_a),
    .O_busy(busy_a), .O_crc(crc_a), .O_crc_valid(crcv_a)
  );

  dvp_cam_emu #(
    .H_ACTIVE(HA_B), .V_ACTIVE(VA_B), .H_BLANK(HB_B), .VS_LINES(VS_B),
    .V_BPORCH(VBP_B), .V_FPORCH(VFP_B), .BPP(BPP_B), .VS_POL(POL_B)
  ) dut_b (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en_b), .I_mode(mode_b),
    .O_vsync(vs_b), .O_href(href_b), .O_pixdata(pix_b), .O_frame_cnt(fc_b),
    .O_busy(busy_b), .O_crc(crc_b), .O_crc_valid(crcv_b)
  );

  always #5 clk = ~clk;

  // Observation mux for the instance under test.
  always_comb begin
    obs_vsync     = sel ? vs_b   : vs_a;
    obs_href      = sel ? href_b : href_a;
    obs_pix       = sel ? pix_b  : pix_a;
    obs_fc        = sel ? fc_b   : fc_a;
    obs_busy      = sel ? busy_b : busy_a;
    obs_crc       = sel ? crc_b  : crc_a;
    obs_crc_valid = sel ? crcv_b : crcv_a;
  end

  function automatic cfg_t get_cfg(bit s);
    cfg_t k;
    if (s) begin
      k.ha = HA_B; k.va = VA_B; k.hb = HB_B; k.vs = VS_B; k.vbp = VBP_B; k.vfp = VFP_B; k.bpp = BPP_B; k.pol = POL_B;
    end else begin
      k.ha = HA_A; k.va = VA_A; k.hb = HB_A; k.vs = VS_A; k.vbp = VBP_A; k.vfp = VFP_A; k.bpp = BPP_A; k.pol = POL_A;
    end
    return k;
  endfunction

  // Expected pins for cycle c of a frame (cycle 0 = first VSYNC clock).
  function automatic exp_t model(cfg_t k, int c, int mode, int fc);
    int l, line, h, x, y;
    logic [9:0] p;
    exp_t e;
    l      = k.ha * k.bpp + k.hb;
    line   = c / l;
    h      = c % l;
    e.vsync  = (line < k.vs) ? k.pol : ~k.pol;
    e.href   = 1'b0;
    e.pix    = 10'h000;
    e.strobe = (c == (k.vs + k.vbp + k.va) * l);
    p = 10'h000;
    if (line >= k.vs + k.vbp && line < k.vs + k.vbp + k.va && h < k.ha * k.bpp) begin
      x = h / k.bpp;
      y = line - k.vs - k.vbp;
      case (mode)
        0:       p = 10'(x);
        1:       p = 10'(y);
        2:       p = ((((x ^ y) >> 3) & 1) != 0) ? 10'h3FF : 10'h000;
        default: p = {8'(fc), 2'b00};
      endcase
      e.href = 1'b1;
      e.pix  = (h % k.bpp == 1) ? ~p : p;
    end
    return e;
  endfunction

  // Reference CRC-16-CCITT, byte-at-a-time formulation.
  function automatic logic [15:0] ref_crc(logic [15:0] crc, logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic set_en(input bit v);
    if (sel) en_b = v; else en_a = v;
  endtask

  task automatic set_mode(input int m);
    if (sel) mode_b = 2'(m); else mode_a = 2'(m);
  endtask

  // Advance to the first negedge showing VSYNC active; bounded.
  task automatic wait_vsync_start(output int waited);
    cfg_t k;
    k = get_cfg(sel);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (obs_vsync !== k.pol && waited < 2000);
    if (obs_vsync !== k.pol) begin
      vectors++;
      miscompares++;
      $display("FAIL vsync_timeout dut=%0d waited=%0d cycles, required vsync=%b", sel, waited, k.pol);
    end
  endtask

  // Check one full frame starting at cycle 0 (current negedge). Ends on the
  // negedge of the following cycle, i.e. cycle 0 of the next frame if enabled.
  task automatic run_frame(input int mode, input int new_mode, input int act_cycle, input bit drop_en);
    cfg_t k;
    exp_t e;
    int flen, fc;
    logic [15:0] crc_ref;
    k       = get_cfg(sel);
    fc      = exp_fc[sel];
    crc_ref = 16'hFFFF;
    flen    = (k.vs + k.vbp + k.va + k.vfp) * (k.ha * k.bpp + k.hb);
    for (int c = 0; c < flen; c++) begin
      if (c > 0) @(negedge clk);
      e = model(k, c, mode, fc);
      vectors++;
      if ({obs_vsync, obs_href, obs_pix} !== {e.vsync, e.href, e.pix}) begin
        miscompares++;
        $display("FAIL stream dut=%0d mode=%0d cyc=%0d got vs=%b href=%b pix=%h, exp vs=%b href=%b pix=%h",
                 sel, mode, c, obs_vsync, obs_href, obs_pix, e.vsync, e.href, e.pix);
      end
      vectors++;
      if (obs_busy !== 1'b1 || obs_fc !== 16'(fc)) begin
        miscompares++;
        $display("FAIL busy_fcnt dut=%0d cyc=%0d got busy=%b fcnt=%0d, exp busy=1 fcnt=%0d", sel, c, obs_busy, obs_fc, fc);
      end
`ifdef DVP_EMU_CRC_EN
      vectors++;
      if (obs_crc_valid !== e.strobe || (e.strobe && obs_crc !== crc_ref)) begin
        miscompares++;
        $display("FAIL crc dut=%0d cyc=%0d got valid=%b crc=%h, exp valid=%b crc=%h", sel, c, obs_crc_valid, obs_crc, e.strobe, crc_ref);
      end
`else
      vectors++;
      if (obs_crc !== 16'h0000 || obs_crc_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL crc_off dut=%0d cyc=%0d got valid=%b crc=%h, exp 0/0000", sel, c, obs_crc_valid, obs_crc);
      end
`endif
      if (e.href) crc_ref = ref_crc(crc_ref, e.pix[9:2]);
      if (c == act_cycle) begin
        set_mode(new_mode);
        if (drop_en) set_en(1'b0);
      end
    end
    @(negedge clk);
    exp_fc[sel] = (fc + 1) & 16'hFFFF;
    vectors++;
    if (obs_fc !== 16'(exp_fc[sel])) begin
      miscompares++;
      $display("FAIL frame_cnt dut=%0d got %0d, exp %0d", sel, obs_fc, exp_fc[sel]);
    end
    vectors++;
    if (obs_vsync !== (drop_en ? ~k.pol : k.pol) || obs_busy !== !drop_en) begin
      miscompares++;
      $display("FAIL frame_end dut=%0d got vs=%b busy=%b, exp vs=%b busy=%b",
               sel, obs_vsync, obs_busy, drop_en ? ~k.pol : k.pol, !drop_en);
    end
    if (drop_en) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        vectors++;
        if (obs_busy !== 1'b0 || obs_vsync !== ~k.pol || obs_href !== 1'b0) begin
          miscompares++;
          $display("FAIL stays_idle dut=%0d i=%0d got busy=%b vs=%b href=%b", sel, i, obs_busy, obs_vsync, obs_href);
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if ({vs_a, href_a, pix_a, fc_a, busy_a, crc_a, crcv_a} !== {~POL_A, 1'b0, 10'h0, 16'h0, 1'b0, 16'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s_a got vs=%b href=%b pix=%h fcnt=%0d busy=%b crc=%h crcv=%b, exp reset values",
               tag, vs_a, href_a, pix_a, fc_a, busy_a, crc_a, crcv_a);
    end
    vectors++;
    if ({vs_b, href_b, pix_b, fc_b, busy_b, crc_b, crcv_b} !== {~POL_B, 1'b0, 10'h0, 16'h0, 1'b0, 16'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s_b got vs=%b href=%b pix=%h fcnt=%0d busy=%b crc=%h crcv=%b, exp reset values",
               tag, vs_b, href_b, pix_b, fc_b, busy_b, crc_b, crcv_b);
    end
  endtask

  task automatic test_reset();
    mode_a = 2'($urandom_range(0, 3));
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy_a !== 1'b0 || vs_a !== ~POL_A || busy_b !== 1'b0 || vs_b !== ~POL_B) begin
      miscompares++;
      $display("FAIL idle_hold got busy_a=%b vs_a=%b busy_b=%b vs_b=%b, exp idle", busy_a, vs_a, busy_b, vs_b);
    end
  endtask

  task automatic test_timing();
    int waited;
    sel = 1'b0;
    mode_a = 2'd0;
    en_a = 1'b1;
    wait_vsync_start(waited);
    vectors++;
    if (waited !== 1) begin
      miscompares++;
      $display("FAIL vsync_latency got %0d clocks, exp 1", waited);
    end
    run_frame(0, 1, 20, 1'b0);
  endtask

  // Back-to-back frames; each frame changes I_mode mid-frame to a new value
  // which must only show up in the following frame.
  task automatic test_back_to_back();
    int cur, nxt;
    int seq[5];
    seq = '{2, 3, 0, 3, 0};
    seq[4] = $urandom_range(0, 3);
    cur = 1;
    for (int i = 0; i < 5; i++) begin
      nxt = seq[i];
      run_frame(cur, nxt, $urandom_range(12, 29), 1'b0);
      cur = nxt;
    end
    run_frame(cur, cur ^ 1, $urandom_range(12, 29), 1'b1);
  endtask

  task automatic test_bpp2();
    int waited;
    sel = 1'b1;
    mode_b = 2'd0;
    en_b = 1'b1;
    wait_vsync_start(waited);
    vectors++;
    if (waited !== 1) begin
      miscompares++;
      $display("FAIL vsync_latency_b got %0d clocks, exp 1", waited);
    end
    run_frame(0, 2, $urandom_range(68, 169), 1'b0);
    run_frame(2, 3, $urandom_range(68, 169), 1'b0);
    run_frame(3, 3, $urandom_range(68, 169), 1'b1);
  endtask

  task automatic test_reset_mid();
    int waited, m;
    sel = 1'b0;
    m = $urandom_range(0, 3);
    mode_a = 2'(m);
    en_a = 1'b1;
    wait_vsync_start(waited);
    repeat ($urandom_range(13, 28)) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_values("reset_mid");
    exp_fc[0] = 0;
    exp_fc[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_vsync_start(waited);
    vectors++;
    if (waited !== 1) begin
      miscompares++;
      $display("FAIL restart_latency got %0d clocks, exp 1", waited);
    end
    run_frame(m, m, 20, 1'b1);
  endtask

  initial begin
    test_reset();
    test_timing();
    test_back_to_back();
    test_bpp2();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dvp_cam_emu.md
Name: dvp_cam_emu

Overview:
- Synthesizable DVP camera-sensor emulator: the transmit end of the OV2640 parallel pixel interface (VSYNC / HREF / 10-bit PIXDATA) that the capture path and frame buffer consume.
- Generates frame/line timing and deterministic test patterns from the system clock.
- Its outputs replace the sensor pins, with PIXCLK tied to I_clk, for bring-up and regression of the capture → HyperRAM → DVI chain without a camera.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_BLANK, 144, blanking clocks after HREF per line (≥1)
- VS_LINES, 3, lines with VSYNC asserted (≥1)
- V_BPORCH, 17, lines between VSYNC deassert and first active line (≥1)
- V_FPORCH, 10, lines after last active line (≥1)
- BPP, 1, bytes per pixel, 1 (RAW10) or 2 (two-byte pixel)
- VS_POL, 1, VSYNC active level

Ports:
- I_clk  in  1  pixel clock; all outputs change on its rising edge
- I_rst_n  in  1  asynchronous active-low reset
- I_en  in  1  run enable, level
- I_mode  in  2  pattern select, latched at frame start
- O_vsync  out  1  frame sync, active level VS_POL
- O_href  out  1  line valid, active high
- O_pixdata  out  10  pixel byte
- O_frame_cnt  out  16  completed frames
- O_busy  out  1  high from frame start to frame end
- O_crc  out  16  frame CRC (optional feature)
- O_crc_valid  out  1  CRC strobe (optional feature)

Behaviour:
- Reset values: O_vsync=~VS_POL, O_href=0, O_pixdata=0, O_frame_cnt=0, O_busy=0, O_crc=0, O_crc_valid=0, FSM=IDLE. Reset applies immediately mid-frame; there is no partial-frame completion.
- All outputs are registered.
- Line length L = H_ACTIVE*BPP + H_BLANK clocks. h_cnt runs 0..L-1; v_cnt counts lines within the current state.
- FSM states:
  - IDLE: I_en=1 sampled → VSYNC; O_vsync goes active on the next edge.
  - VSYNC: O_vsync active for VS_LINES*L clocks → VBP.
  - VBP: V_BPORCH*L clocks → ACTIVE.
  - ACTIVE: V_ACTIVE lines. O_href=1 for h_cnt 0..H_ACTIVE*BPP-1, then 0 for H_BLANK clocks.
  - VFP: V_FPORCH*L clocks. On the last clock, O_frame_cnt increments (wraps 0xFFFF→0). Then go to VSYNC if I_en=1, otherwise IDLE.
- O_busy=1 in VSYNC/VBP/ACTIVE/VFP.
- I_en deasserted mid-frame: the frame completes, then the FSM stops in IDLE.
- I_mode changes mid-frame are ignored; the value is latched on the IDLE/VFP→VSYNC transition.
- Pattern value P[9:0], with x = pixel index 0..H_ACTIVE-1 and y = active line 0..V_ACTIVE-1:
  - mode 0: P = x[9:0]
  - mode 1: P = y[9:0]
  - mode 2: P = (x[3]^y[3]) ? 10'h3FF : 10'h000
  - mode 3: P = {O_frame_cnt[7:0], 2'b00}
- BPP=1: O_pixdata=P each HREF clock.
- BPP=2: first byte P, second byte ~P; x advances every 2 clocks.
- O_pixdata=0 whenever O_href=0.

Optional Feature:
- Macro: DVP_EMU_CRC_EN.
- Defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR) over O_pixdata[9:2] on every clock with O_href=1.
  - Reset to 0xFFFF at VSYNC entry.
  - On the first VFP clock, O_crc loads the result and O_crc_valid pulses for 1 clock.
- Undefined: O_crc=0 and O_crc_valid=0 constantly; no CRC logic is synthesized.

Test Plan:
- Timing: H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, VS_LINES=1, V_BPORCH=1, V_FPORCH=1, BPP=1, VS_POL=1; I_en=1 from reset release → O_vsync high 6 clocks; O_href rises at clock 12 after VSYNC start; 3 HREF pulses of 4 clocks, 6-clock period; frame period 36 clocks; O_frame_cnt=1 after first frame.
- Mode 0, same parameters → each line O_pixdata = 0,1,2,3. Mode 1 → line y carries y,y,y,y. Mode 2 with H_ACTIVE=16 → 0x000 ×8 then 0x3FF ×8 on line 0.
- BPP=2, mode 0 → HREF 8 clocks per line, bytes 0x000, 0x3FF, 0x001, 0x3FE, ...
- I_en dropped during ACTIVE → current frame completes, O_busy falls after the last VFP clock, O_vsync stays inactive; I_mode changed mid-frame takes effect only on the next frame.
- Async I_rst_n pulse mid-line → all outputs at reset values within the same cycle; a restart produces a full frame starting with VSYNC.
- DVP_EMU_CRC_EN defined, 4x3 frame, mode 0 → O_crc_valid single pulse on the first VFP clock; O_crc equals a reference CRC-16-CCITT over bytes {0x00, 0x00, 0x00, 0x00} (P[9:2] of 0..3) repeated 3 times; undefined build → O_crc stays 0.
